// File: rtl/mpmc10_port_arbiter_if.sv
// rtl/mpmc10_port_arbiter_if.sv - port FIFO read side and sequencer request bundle
interface mpmc10_port_arbiter_if #(
    parameter int NPORT = 8,
    parameter int REQW  = 128,
    parameter int PW    = $clog2(NPORT)
);
    logic [NPORT-1:0]           fifo_empty;
    logic [NPORT-1:0]           fifo_rst_busy;
    logic [NPORT-1:0]           fifo_v;
    logic [NPORT-1:0][REQW-1:0] fifo_req;
    logic [NPORT-1:0]           fifo_rd;
    logic [REQW-1:0]            req_o;
    logic [PW-1:0]              req_port;
    logic                       req_valid;
    logic                       req_ready;

    modport master (
        input  fifo_empty, fifo_rst_busy, fifo_v, fifo_req, req_ready,
        output fifo_rd, req_o, req_port, req_valid
    );

    modport slave (
        output fifo_empty, fifo_rst_busy, fifo_v, fifo_req, req_ready,
        input  fifo_rd, req_o, req_port, req_valid
    );
endinterface

// File: rtl/mpmc10_port_arbiter.sv
// rtl/mpmc10_port_arbiter.sv - round-robin pop of mpmc10 port FIFOs onto a valid/ready request
module mpmc10_port_arbiter #(
    parameter int NPORT = 8,
    parameter int PW    = $clog2(NPORT),
    parameter int TMO   = 7,
    parameter int REQW  = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    mpmc10_port_arbiter_if.master   bus,
    output logic                    busy,
    output logic                    tmo_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    sel_q, sel_d;
    logic [PW-1:0]    last_q, last_d;
    logic [PW-1:0]    req_port_q, req_port_d;
    logic [NPORT-1:0] fifo_rd_q, fifo_rd_d;
    logic [REQW-1:0]  req_o_q, req_o_d;
    logic             req_valid_q, req_valid_d;
    logic             tmo_err_q, tmo_err_d;
    logic             busy_q, busy_d;
    logic [7:0]       timer_q, timer_d;

    logic [NPORT-1:0] eligible;
    logic [PW-1:0]    grant;
    logic             any_elig;
    int unsigned      scan_idx;
    logic [PW-1:0]    scan_p;

    assign eligible = ~bus.fifo_empty & ~bus.fifo_rst_busy;

    // Walk offsets from farthest to nearest so the nearest eligible port after last wins.
    always_comb begin
        grant    = last_q;
        any_elig = 1'b0;
        scan_idx = 0;
        scan_p   = '0;
        for (int k = NPORT; k >= 1; k--) begin
            scan_idx = int'(last_q) + k;
            if (scan_idx >= NPORT) begin
                scan_idx = scan_idx - NPORT;
            end
            scan_p = PW'(scan_idx);
            if (eligible[scan_p]) begin
                grant    = scan_p;
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        fifo_rd_d   = '0;
        req_o_d     = req_o_q;
        req_port_d  = req_port_q;
        req_valid_d = req_valid_q;
        tmo_err_d   = 1'b0;
        timer_d     = timer_q;

        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    sel_d            = grant;
                    last_d           = grant;
                    fifo_rd_d[grant] = 1'b1;
                    state_d          = POP;
                end
            end
            POP: begin
                timer_d = '0;
                state_d = CAPT;
            end
            CAPT: begin
                if (bus.fifo_v[sel_q]) begin
                    req_o_d     = bus.fifo_req[sel_q];
                    req_port_d  = sel_q;
                    req_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (timer_q == 8'(TMO - 1)) begin
                    tmo_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            HOLD: begin
                if (req_valid_q && bus.req_ready) begin
                    req_valid_d = 1'b0;
                    // Re-arbitrate in the accept cycle to save a trip through IDLE.
                    if (any_elig) begin
                        sel_d            = grant;
                        last_d           = grant;
                        fifo_rd_d[grant] = 1'b1;
                        state_d          = POP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            last_q      <= PW'(NPORT - 1);
            fifo_rd_q   <= '0;
            req_o_q     <= '0;
            req_port_q  <= '0;
            req_valid_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            fifo_rd_q   <= fifo_rd_d;
            req_o_q     <= req_o_d;
            req_port_q  <= req_port_d;
            req_valid_q <= req_valid_d;
            tmo_err_q   <= tmo_err_d;
            busy_q      <= busy_d;
            timer_q     <= timer_d;
        end
    end

    assign bus.fifo_rd   = fifo_rd_q;
    assign bus.req_o     = req_o_q;
    assign bus.req_port  = req_port_q;
    assign bus.req_valid = req_valid_q;
    assign busy          = busy_q;
    assign tmo_err       = tmo_err_q;
endmodule

// File: tb/tb_mpmc10_port_arbiter.sv
// tb/tb_mpmc10_port_arbiter.sv - scoreboard bench for mpmc10_port_arbiter
module tb_mpmc10_port_arbiter;
    localparam int NPORT = 8;
    localparam int PW    = 3;
    localparam int TMO   = 7;
    localparam int REQW  = 128;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic tmo_err;

    mpmc10_port_arbiter_if #(.NPORT(NPORT), .REQW(REQW), .PW(PW)) bus ();

    mpmc10_port_arbiter #(.NPORT(NPORT), .PW(PW), .TMO(TMO), .REQW(REQW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .tmo_err (tmo_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [REQW-1:0]  mem [NPORT][16];
    int               wr_cnt [NPORT];
    int               rd_cnt [NPORT];
    logic [NPORT-1:0] no_valid;
    logic [NPORT-1:0] pend;

    int              exp_port [$];
    logic [REQW-1:0] exp_data [$];
    int              acc_cyc  [$];

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [REQW-1:0] mk_req(input int p, input int s);
        logic [7:0] tag;
        tag = 8'(p * 17);
        return {104'h0, 8'(p), 8'(s), tag};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_req(input int p);
        mem[p][wr_cnt[p] % 16] = mk_req(p, wr_cnt[p]);
        wr_cnt[p]++;
    endtask

    task automatic expect_req(input int p, input int s);
        exp_port.push_back(p);
        exp_data.push_back(mk_req(p, s));
    endtask

    task automatic clear_model();
        for (int i = 0; i < NPORT; i++) begin
            wr_cnt[i] = 0;
            rd_cnt[i] = 0;
        end
        no_valid = '0;
        bus.fifo_rst_busy = '0;
        exp_port.delete();
        exp_data.delete();
        acc_cyc.delete();
    endtask

    task automatic hw_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        int n;
        n = 0;
        while (exp_port.size() != 0 && n < maxc) begin
            tick();
            n++;
        end
        check_eq(tag, 160'(exp_port.size()), 160'(0));
    endtask

    task automatic wait_valid(input string tag, input int maxc);
        int n;
        n = 0;
        while (!bus.req_valid && n < maxc) begin
            tick();
            n++;
        end
        check_eq(tag, 160'(bus.req_valid), 160'(1));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Port FIFO model: data_valid one cycle after the read strobe is sampled.
    initial begin
        bus.fifo_v     = '0;
        bus.fifo_req   = '0;
        bus.fifo_empty = '1;
        pend           = '0;
        forever begin
            @(negedge clk);
            bus.fifo_v = '0;
            if (rst) begin
                pend = '0;
            end else begin
                for (int i = 0; i < NPORT; i++) begin
                    if (pend[i] && !no_valid[i] && rd_cnt[i] != wr_cnt[i]) begin
                        bus.fifo_v[i]   = 1'b1;
                        bus.fifo_req[i] = mem[i][rd_cnt[i] % 16];
                        rd_cnt[i]++;
                    end
                    pend[i] = bus.fifo_rd[i];
                end
            end
            for (int i = 0; i < NPORT; i++) begin
                bus.fifo_empty[i] = (rd_cnt[i] == wr_cnt[i]);
            end
        end
    end

    initial begin
        int              ep;
        logic [REQW-1:0] ed;
        forever begin
            @(negedge clk);
            if (!rst && bus.req_valid && bus.req_ready) begin
                acc_cyc.push_back(cyc);
                check_eq("acc_expected", 160'(exp_port.size() != 0), 160'(1));
                if (exp_port.size() != 0) begin
                    ep = exp_port.pop_front();
                    ed = exp_data.pop_front();
                    check_eq("acc_port", 160'(bus.req_port), 160'(ep));
                    check_eq("acc_data", 160'(bus.req_o), 160'(ed));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] held;
        logic [REQW-1:0] ro;
        int n;

        rst = 1'b1;
        bus.req_ready = 1'b0;
        clear_model();
        hw_reset();

        check_eq("rst_ctrl", 160'({bus.req_valid, bus.fifo_rd, busy, tmo_err}), 160'(0));
        check_eq("rst_port", 160'(bus.req_port), 160'(0));
        check_eq("rst_req",  160'(bus.req_o), 160'(0));

        // Single port latency
        push_req(3);
        expect_req(3, 0);
        tick();
        check_eq("t1_rd", 160'(bus.fifo_rd), 160'(8'h08));
        check_eq("t1_busy", 160'(busy), 160'(1));
        tick();
        check_eq("t1_rd_off", 160'({bus.fifo_rd, bus.req_valid}), 160'(0));
        tick();
        ro = bus.req_o;
        check_eq("t1_valid", 160'({bus.req_valid, bus.req_port}), 160'({1'b1, 3'd3}));
        check_eq("t1_tag", 160'(ro[7:0]), 160'(8'h33));
        bus.req_ready = 1'b1;
        tick();
        check_eq("t1_accept", 160'({bus.req_valid, busy}), 160'(0));

        // Round robin over 0,2,5 with ready held high
        clear_model();
        hw_reset();
        bus.req_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push_req(0);
            push_req(2);
            push_req(5);
        end
        for (int r = 0; r < 2; r++) begin
            expect_req(0, r);
            expect_req(2, r);
            expect_req(5, r);
        end
        wait_drain("t2_drain", 60);
        check_eq("t2_count", 160'(acc_cyc.size()), 160'(6));
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check_eq("t2_spacing", 160'(acc_cyc[i] - acc_cyc[i-1]), 160'(3));
        end

        // Backpressure hold
        clear_model();
        hw_reset();
        bus.req_ready = 1'b0;
        push_req(1);
        push_req(6);
        expect_req(1, 0);
        expect_req(6, 0);
        wait_valid("t3_valid", 10);
        held = 160'({bus.req_valid, bus.req_port, bus.req_o, bus.fifo_rd});
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("t3_hold", 160'({bus.req_valid, bus.req_port, bus.req_o, bus.fifo_rd}), held);
        end
        bus.req_ready = 1'b1;
        tick();
        check_eq("t3_release", 160'(bus.req_valid), 160'(0));
        check_eq("t3_next_pop", 160'(bus.fifo_rd), 160'(8'h40));
        wait_drain("t3_drain", 20);

        // data_valid timeout
        clear_model();
        hw_reset();
        bus.req_ready = 1'b1;
        no_valid[1] = 1'b1;
        push_req(1);
        push_req(6);
        expect_req(6, 0);
        n = 0;
        while (bus.fifo_rd != 8'h02 && n < 10) begin
            tick();
            n++;
        end
        check_eq("t4_pop", 160'(bus.fifo_rd), 160'(8'h02));
        n = 0;
        while (!tmo_err && n < 20) begin
            tick();
            n++;
        end
        check_eq("t4_tmo_lat", 160'(n), 160'(8));
        check_eq("t4_idle", 160'({busy, bus.req_valid}), 160'(0));
        rd_cnt[1] = wr_cnt[1];
        no_valid[1] = 1'b0;
        tick();
        check_eq("t4_pulse", 160'(tmo_err), 160'(0));
        check_eq("t4_next", 160'(bus.fifo_rd), 160'(8'h40));
        wait_drain("t4_drain", 20);

        // Skip a port in rd_rst_busy
        clear_model();
        hw_reset();
        bus.req_ready = 1'b1;
        bus.fifo_rst_busy = 8'h10;
        for (int p = 0; p < NPORT; p++) begin
            push_req(p);
        end
        expect_req(0, 0);
        expect_req(1, 0);
        expect_req(2, 0);
        expect_req(3, 0);
        expect_req(5, 0);
        expect_req(6, 0);
        expect_req(7, 0);
        wait_drain("t5_skip", 60);
        check_eq("t5_idle", 160'(busy), 160'(0));
        expect_req(4, 0);
        bus.fifo_rst_busy = '0;
        wait_drain("t5_release", 20);

        // Reset while holding a request
        clear_model();
        hw_reset();
        bus.req_ready = 1'b0;
        push_req(2);
        push_req(5);
        expect_req(2, 0);
        wait_valid("t6_valid", 10);
        check_eq("t6_port", 160'(bus.req_port), 160'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_rst", 160'({bus.req_valid, bus.fifo_rd, busy}), 160'(0));
        exp_port.delete();
        exp_data.delete();
        push_req(1);
        expect_req(1, 0);
        expect_req(5, 0);
        bus.req_ready = 1'b1;
        wait_drain("t6_lowest", 30);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
